// File: rtl/disp_share_arbiter_if.sv
// rtl/disp_share_arbiter_if.sv - requester/display bundle for the shared 7-seg arbiter
interface disp_share_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]    i_req;
    logic [N_REQ*40-1:0] i_dig_flat;
    logic [N_REQ-1:0]    o_gnt;
    logic [2:0]          o_cs_pointer;
    logic [4:0]          o_dig_ctrl;
    logic                o_busy;

    modport master (
        output i_req,
        output i_dig_flat,
        input  o_gnt,
        input  o_cs_pointer,
        input  o_dig_ctrl,
        input  o_busy
    );

    modport slave (
        input  i_req,
        input  i_dig_flat,
        output o_gnt,
        output o_cs_pointer,
        output o_dig_ctrl,
        output o_busy
    );
endinterface

// File: rtl/disp_share_arbiter.sv
// rtl/disp_share_arbiter.sv - round-robin owner of the 8-digit scanned display
module disp_share_arbiter #(
    parameter int         N_REQ      = 3,
    parameter int         HOLD_CYC   = 500,
    parameter int         BLANK_CYC  = 2,
    parameter logic [4:0] BLANK_CODE = 5'h0F
) (
    input  logic                 clk_alt,
    input  logic                 i_rst_n,
    disp_share_arbiter_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HC_W  = $clog2(HOLD_CYC + 1);
    localparam int BC_W  = $clog2(BLANK_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [4:0]        dig_q, dig_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  rr_last_q, rr_last_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic [BC_W-1:0]   blank_q, blank_d;
    logic [39:0]       frame_q, frame_d;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  cand;
    logic [39:0]       win_row;
    logic [39:0]       own_row;
    logic              owner_req;
    logic              others_req;
    logic              hold_expired;

    // While granted, rr_last_q is the current owner, so its row feeds frame reloads.
    assign win_row      = 40'(bus.i_dig_flat >> (int'(win_idx) * 40));
    assign own_row      = 40'(bus.i_dig_flat >> (int'(rr_last_q) * 40));
    assign owner_req    = |(bus.i_req & gnt_q);
    assign others_req   = |(bus.i_req & ~gnt_q);
    assign hold_expired = (hold_q >= HC_W'(HOLD_CYC - 1));

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(rr_last_q) + k) % N_REQ);
            if (!win_found && |(bus.i_req & (N_REQ'(1) << cand))) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state, grant, counters, frame snapshot and the scanned digit code.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_last_d = rr_last_q;
        hold_d    = hold_q;
        blank_d   = blank_q;
        frame_d   = frame_q;
        ptr_d     = ptr_q + 3'd1;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d   = ST_GRANT;
                    gnt_d     = N_REQ'(1) << win_idx;
                    rr_last_d = win_idx;
                    hold_d    = '0;
                    frame_d   = win_row;
                end
            end
            ST_GRANT: begin
                if (hold_q != HC_W'(HOLD_CYC)) begin
                    hold_d = hold_q + HC_W'(1);
                end
                if (!owner_req || (hold_expired && others_req)) begin
                    state_d = ST_BLANK;
                    gnt_d   = '0;
                    blank_d = '0;
                end else if (ptr_q == 3'd7) begin
                    // Reload only at frame boundary so a frame never mixes old and new digits.
                    frame_d = own_row;
                end
            end
            ST_BLANK: begin
                if (blank_q >= BC_W'(BLANK_CYC - 1)) begin
                    if (win_found) begin
                        state_d   = ST_GRANT;
                        gnt_d     = N_REQ'(1) << win_idx;
                        rr_last_d = win_idx;
                        hold_d    = '0;
                        frame_d   = win_row;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    blank_d = blank_q + BC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        // Code is registered together with the pointer so both change on the same edge.
        if (state_d == ST_GRANT) begin
            dig_d = 5'(frame_d >> (6'(ptr_d) * 6'd5));
        end else begin
            dig_d = BLANK_CODE;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_alt or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            dig_q     <= BLANK_CODE;
            gnt_q     <= '0;
            rr_last_q <= IDX_W'(N_REQ - 1);
            hold_q    <= '0;
            blank_q   <= '0;
            frame_q   <= {8{BLANK_CODE}};
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            dig_q     <= dig_d;
            gnt_q     <= gnt_d;
            rr_last_q <= rr_last_d;
            hold_q    <= hold_d;
            blank_q   <= blank_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.o_gnt        = gnt_q;
    assign bus.o_cs_pointer = ptr_q;
    assign bus.o_dig_ctrl   = dig_q;
    assign bus.o_busy       = (state_q != ST_IDLE);
endmodule
